irq_exc_ctrl: RTL and testbench
===============================

Name: irq_exc_ctrl

Overview:
- Parametrised successor to the pipeline's exception/interrupt unit.
- Merges internal MEM-stage exception vectors with NUM_IRQ active-low external interrupt lines.
- External lines pass through a synchroniser, a mask register and fixed priority.
- Drives the exception/vector pair used by the IF, ID and EX flushes, the IAR capture and the SR. Issues per-channel IACK_n pulses and tracks nested service on a LIFO stack popped by rfe.

Parameters:
NUM_IRQ, 3, number of external interrupt lines (1..16); channel 0 is highest priority
VEC_W, 5, width of the vector code
VEC_BASE, 8, vector for channel 0; channel k maps to VEC_BASE+k. Constraint: VEC_BASE+NUM_IRQ-1 < 2^VEC_W and no overlap with internal codes
MAX_NEST, 4, stack depth (1..8)
HOLDOFF, 2, cycles after any exception during which no external interrupt may be taken (covers SR IE update latency)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
oint_n  in  NUM_IRQ  external interrupt requests, active-low level, asynchronous to clk
ie  in  1  global interrupt enable from SR
rfe  in  1  return-from-exception, MEM stage
vector_mem  in  VEC_W  internal exception vector from MEM stage; 0 means none
mask_we  in  1  mask register write strobe
mask_wdata  in  NUM_IRQ  new mask value; 1 = masked
exception  out  1  exception taken this cycle (internal or external)
vector  out  VEC_W  vector of the taken exception; 0 when exception=0
iack_n  out  NUM_IRQ  per-channel acknowledge, active-low, single-cycle
mask  out  NUM_IRQ  current mask register
pending  out  NUM_IRQ  synchronised, unmasked requests
nest_depth  out  clog2(MAX_NEST+1)  stack occupancy
nest_ovf  out  1  sticky stack-overflow flag

Behaviour:
- Reset (rst=0, asynchronous):
  - synchroniser flops = all-ones; mask=0; stack empty; nest_depth=0; nest_ovf=0; holdoff counter=0; state IDLE.
  - Outputs: exception=0, vector=0, iack_n=all-ones.
  - Reset asserted mid-service discards the whole stack.
- Synchroniser: two flops per line. A level change on oint_n is visible on pending 2 cycles later. pending = ~sync2 & ~mask.
- Mask register: written at the clock edge when mask_we=1. The new mask affects pending from the next cycle.
- Current level L:
  - L = channel of the most recently pushed external entry on the stack.
  - L = NUM_IRQ if the stack holds no external entry.
- Eligible channels: pending bits with index < L. Winner = lowest eligible index.
- Decision is combinational, i.e. exception, vector and iack_n are valid in the same cycle as their cause:
  1. Internal: vector_mem != 0 → exception=1, vector=vector_mem. This is unconditional (ignores ie, holdoff and depth). Push {int} onto the stack. Any rfe in the same cycle is ignored.
  2. Otherwise, rfe=1 → pop the stack (no-op if empty). No external take this cycle.
  3. Otherwise, external take when all of: ie=1, state IDLE, nest_depth < MAX_NEST, a winner k exists. Then exception=1, vector=VEC_BASE+k, iack_n[k]=0 for this one cycle, and push {ext,k}.
  4. Otherwise exception=0, vector=0.
- State machine:
  - IDLE → HOLD on any exception; the counter loads HOLDOFF-1.
  - HOLD decrements each cycle and returns to IDLE when it reaches 0. HOLDOFF=0 means HOLD is never entered.
  - An internal exception during HOLD reloads the counter.
- Stack overflow: a push with nest_depth=MAX_NEST still reports the exception but discards the push and sets nest_ovf. nest_ovf clears only on reset.
- Equal or lower priority requests stay pending, without an ack, until an rfe lowers L. The device must keep oint_n low until it sees its iack_n.
- A request that deasserts before it is taken is lost silently.

Test Plan:
- Reset with oint_n=3'b110, ie=1; release rst → no exception for 2 cycles; 3rd cycle exception=1, vector=8, iack_n=3'b110, nest_depth=1.
- Channel 2 in service (vector 10); then oint_n[0] goes low → taken after holdoff, vector=8, depth=2. Channel 1 requested while L=0 → no take. rfe → L=2 → channel 1 taken, vector=9.
- vector_mem=5'b10010 with rfe=1 and oint_n[0] low in the same cycle → exception=1, vector=18, no iack, stack push only, rfe ignored.
- mask_wdata=3'b001 written, oint_n[0] low, ie=1 → pending=0, no take; unmask → taken 1 cycle later with vector=8.
- MAX_NEST=2, stack full, internal vector 16 → exception=1, vector=16, nest_ovf=1, depth stays 2. Same state with an external request → no take.
- ie=0 with oint_n[1] low for 10 cycles → no exception, pending=3'b010; ie→1 → take in that same cycle, vector=9.

Source files
------------

// File: rtl/irq_exc_ctrl.sv
// Exception/interrupt controller: merges MEM-stage exception vectors with
// synchronised, masked, fixed-priority external interrupts and tracks nesting.
module irq_exc_ctrl #(
  parameter int NUM_IRQ  = 3,
  parameter int VEC_W    = 5,
  parameter int VEC_BASE = 8,
  parameter int MAX_NEST = 4,
  parameter int HOLDOFF  = 2,
  localparam int DEPTH_W = $clog2(MAX_NEST + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] oint_n,
  input  logic               ie,
  input  logic               rfe,
  input  logic [VEC_W-1:0]   vector_mem,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic               exception,
  output logic [VEC_W-1:0]   vector,
  output logic [NUM_IRQ-1:0] iack_n,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic [DEPTH_W-1:0] nest_depth,
  output logic               nest_ovf
);

  localparam int CH_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int LVL_W  = $clog2(NUM_IRQ + 1);
  localparam int SP_W   = (MAX_NEST > 1) ? $clog2(MAX_NEST) : 1;
  localparam int HCNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef struct packed {
    logic            ext;
    logic [CH_W-1:0] ch;
  } entry_t;

  typedef enum logic [1:0] {ACT_NONE, ACT_INT, ACT_POP, ACT_EXT} act_e;
  typedef enum logic {IDLE, HOLD} state_e;

  logic [NUM_IRQ-1:0] sync1, sync2;
  entry_t             stack [MAX_NEST];
  entry_t             push_entry;
  logic [LVL_W-1:0]   level;
  logic               win_valid;
  logic [CH_W-1:0]    win_ch;
  logic [NUM_IRQ-1:0] win_oh;
  act_e               act;
  state_e             state;
  logic [HCNT_W-1:0]  hold_cnt;
  logic               push;
  logic               stack_full;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source; blocking here would collapse the two
  // synchroniser stages into one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= oint_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         mask <= '0;
    else if (mask_we) mask <= mask_wdata;
  end

  assign pending = ~sync2 & ~mask;

  // Current level: channel of the topmost external entry, NUM_IRQ if none.
  // NOTE: every combinational output gets a default before any condition so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    level = LVL_W'(NUM_IRQ);
    for (int i = 0; i < MAX_NEST; i++) begin
      if (i < int'(nest_depth) && stack[i].ext) level = LVL_W'(stack[i].ch);
    end
  end

  always_comb begin
    win_valid = 1'b0;
    win_ch    = '0;
    win_oh    = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (!win_valid && pending[k] && k < int'(level)) begin
        win_valid = 1'b1;
        win_ch    = CH_W'(k);
        win_oh[k] = 1'b1;
      end
    end
  end

  // Internal exceptions beat rfe, which beats any external take.
  always_comb begin
    act       = ACT_NONE;
    exception = 1'b0;
    vector    = '0;
    iack_n    = '1;
    if (rst) begin
      if (vector_mem != '0) begin
        act       = ACT_INT;
        exception = 1'b1;
        vector    = vector_mem;
      end else if (rfe) begin
        act = ACT_POP;
      end else if (ie && state == IDLE && nest_depth < DEPTH_W'(MAX_NEST) && win_valid) begin
        act       = ACT_EXT;
        exception = 1'b1;
        vector    = VEC_W'(VEC_BASE) + VEC_W'(win_ch);
        iack_n    = ~win_oh;
      end
    end
  end

  // Holdoff window after any exception covers the SR IE update latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else if (exception && HOLDOFF > 0) begin
      state    <= HOLD;
      hold_cnt <= HCNT_W'(HOLDOFF - 1);
    end else if (state == HOLD) begin
      if (hold_cnt == '0) state <= IDLE;
      else                hold_cnt <= hold_cnt - HCNT_W'(1);
    end
  end

  assign push       = (act == ACT_INT) || (act == ACT_EXT);
  assign stack_full = (nest_depth == DEPTH_W'(MAX_NEST));
  assign push_entry = '{ext: (act == ACT_EXT), ch: (act == ACT_EXT) ? win_ch : '0};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nest_depth <= '0;
      nest_ovf   <= 1'b0;
    end else if (push) begin
      if (stack_full) nest_ovf <= 1'b1;
      else            nest_depth <= nest_depth + DEPTH_W'(1);
    end else if (act == ACT_POP && nest_depth != '0) begin
      nest_depth <= nest_depth - DEPTH_W'(1);
    end
  end

  // NOTE: the entry array has no reset; nest_depth gates every read, so
  // clearing nest_depth alone discards the whole stack.
  always_ff @(posedge clk) begin
    if (push && !stack_full) stack[nest_depth[SP_W-1:0]] <= push_entry;
  end

endmodule

// File: tb/tb_irq_exc_ctrl.sv
// Self-checking bench for irq_exc_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based behavioural model.
module tb_irq_exc_ctrl;

  localparam int NUM_IRQ  = 3;
  localparam int VEC_W    = 5;
  localparam int VEC_BASE = 8;
  localparam int MAX_NEST = 4;
  localparam int HOLDOFF  = 2;
  localparam int DEPTH_W  = $clog2(MAX_NEST + 1);
  localparam int OBS_W    = 1 + VEC_W + 3 * NUM_IRQ + DEPTH_W + 1;

  localparam int K_NONE = 0, K_INT = 1, K_POP = 2, K_EXT = 3;

  logic               clk        = 1'b0;
  logic               rst        = 1'b0;
  logic [NUM_IRQ-1:0] oint_n     = '1;
  logic               ie         = 1'b0;
  logic               rfe        = 1'b0;
  logic [VEC_W-1:0]   vector_mem = '0;
  logic               mask_we    = 1'b0;
  logic [NUM_IRQ-1:0] mask_wdata = '0;
  logic               exception;
  logic [VEC_W-1:0]   vector;
  logic [NUM_IRQ-1:0] iack_n;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] pending;
  logic [DEPTH_W-1:0] nest_depth;
  logic               nest_ovf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  irq_exc_ctrl #(
    .NUM_IRQ(NUM_IRQ), .VEC_W(VEC_W), .VEC_BASE(VEC_BASE),
    .MAX_NEST(MAX_NEST), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .rst(rst), .oint_n(oint_n), .ie(ie), .rfe(rfe),
    .vector_mem(vector_mem), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .exception(exception), .vector(vector), .iack_n(iack_n), .mask(mask),
    .pending(pending), .nest_depth(nest_depth), .nest_ovf(nest_ovf)
  );

  // Behavioural model: a queue stack, a two-deep delay line for the line
  // levels, and a count of cycles still blocked after the last exception.
  typedef struct {
    bit ext;
    int ch;
  } ent_t;

  ent_t               m_stk[$];
  logic [NUM_IRQ-1:0] m_s1, m_s2, m_mask;
  int                 m_hold;
  bit                 m_ovf;

  function automatic void model_decide(output int kind, output int win);
    logic [NUM_IRQ-1:0] pend;
    int level;
    pend  = ~m_s2 & ~m_mask;
    level = NUM_IRQ;
    foreach (m_stk[i]) if (m_stk[i].ext) level = m_stk[i].ch;
    win = -1;
    for (int k = NUM_IRQ - 1; k >= 0; k--) if (pend[k] && k < level) win = k;
    if (vector_mem != '0) kind = K_INT;
    else if (rfe) kind = K_POP;
    else if (ie && m_hold == 0 && m_stk.size() < MAX_NEST && win >= 0) kind = K_EXT;
    else kind = K_NONE;
  endfunction

  function automatic void model_push(bit ext, int ch);
    ent_t e;
    e.ext = ext;
    e.ch  = ch;
    if (m_stk.size() == MAX_NEST) m_ovf = 1'b1;
    else m_stk.push_back(e);
  endfunction

  function automatic void model_step();
    int kind, win;
    if (!rst) begin
      m_stk.delete();
      m_s1 = '1; m_s2 = '1; m_mask = '0; m_hold = 0; m_ovf = 1'b0;
    end else begin
      model_decide(kind, win);
      if (kind == K_INT) model_push(1'b0, 0);
      else if (kind == K_EXT) model_push(1'b1, win);
      else if (kind == K_POP && m_stk.size() > 0) void'(m_stk.pop_back());
      if (kind == K_INT || kind == K_EXT) m_hold = HOLDOFF;
      else if (m_hold > 0) m_hold--;
      if (mask_we) m_mask = mask_wdata;
      m_s2 = m_s1;
      m_s1 = oint_n;
    end
  endfunction

  // Every clock edge of the bench passes through here so the model stays in step.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    oint_n = '1; ie = 1'b0; rfe = 1'b0; vector_mem = '0; mask_we = 1'b0; mask_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    oint_n = 3'b110;
    ie     = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({exception, vector, iack_n, mask, pending, nest_depth, nest_ovf} !== {1'b0, 5'd0, 3'b111, 3'b000, 3'b000, 3'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got %b want %b", {exception, vector, iack_n, mask, pending, nest_depth, nest_ovf},
               {1'b0, 5'd0, 3'b111, 3'b000, 3'b000, 3'd0, 1'b0});
    end
    tick();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if (exception !== 1'b0) begin
        n_errors++;
        $display("FAIL reset_quiet cycle %0d: got exception=%b want 0", c, exception);
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if ({exception, vector, iack_n} !== {1'b1, 5'd8, 3'b110}) begin
      n_errors++;
      $display("FAIL first_take: got %b want %b", {exception, vector, iack_n}, {1'b1, 5'd8, 3'b110});
    end
    tick();
    oint_n = 3'b111;
    @(negedge clk);
    n_checks++;
    if (nest_depth !== 3'd1) begin
      n_errors++;
      $display("FAIL first_depth: got %0d want 1", nest_depth);
    end
  endtask

  task automatic test_nesting();
    int wait_c;
    bit seen;
    do_reset();
    ie = 1'b1;
    oint_n = 3'b011;
    wait_c = 0;
    @(negedge clk);
    while (!exception && wait_c < 8) begin tick(); @(negedge clk); wait_c++; end
    n_checks++;
    if ({exception, vector, iack_n} !== {1'b1, 5'd10, 3'b011}) begin
      n_errors++;
      $display("FAIL nest_ch2_take: got %b want %b", {exception, vector, iack_n}, {1'b1, 5'd10, 3'b011});
    end
    tick();
    oint_n = 3'b110;
    wait_c = 0;
    @(negedge clk);
    while (!exception && wait_c < 8) begin tick(); @(negedge clk); wait_c++; end
    n_checks++;
    if (wait_c !== 2) begin
      n_errors++;
      $display("FAIL nest_ch0_delay: got %0d idle cycles want 2", wait_c);
    end
    n_checks++;
    if ({exception, vector, iack_n} !== {1'b1, 5'd8, 3'b110}) begin
      n_errors++;
      $display("FAIL nest_ch0_take: got %b want %b", {exception, vector, iack_n}, {1'b1, 5'd8, 3'b110});
    end
    tick();
    oint_n = 3'b101;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (exception) seen = 1'b1; tick(); end
    @(negedge clk);
    n_checks++;
    if ({seen, pending, nest_depth} !== {1'b0, 3'b010, 3'd2}) begin
      n_errors++;
      $display("FAIL nest_blocked: got seen/pending/depth %b want %b", {seen, pending, nest_depth}, {1'b0, 3'b010, 3'd2});
    end
    tick();
    rfe = 1'b1;
    @(negedge clk);
    n_checks++;
    if (exception !== 1'b0) begin
      n_errors++;
      $display("FAIL nest_rfe_cycle: got exception=%b want 0", exception);
    end
    tick();
    rfe = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({exception, vector, iack_n, nest_depth} !== {1'b1, 5'd9, 3'b101, 3'd1}) begin
      n_errors++;
      $display("FAIL nest_ch1_after_rfe: got %b want %b", {exception, vector, iack_n, nest_depth}, {1'b1, 5'd9, 3'b101, 3'd1});
    end
  endtask

  task automatic test_internal_priority();
    do_reset();
    ie = 1'b1;
    oint_n = 3'b110;
    tick();
    tick();
    vector_mem = 5'b10010;
    rfe = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({exception, vector, iack_n, pending} !== {1'b1, 5'd18, 3'b111, 3'b001}) begin
      n_errors++;
      $display("FAIL int_over_all: got %b want %b", {exception, vector, iack_n, pending}, {1'b1, 5'd18, 3'b111, 3'b001});
    end
    tick();
    vector_mem = '0;
    rfe = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({exception, nest_depth} !== {1'b0, 3'd1}) begin
        n_errors++;
        $display("FAIL int_holdoff cycle %0d: got %b want %b", c, {exception, nest_depth}, {1'b0, 3'd1});
      end
      tick();
    end
    @(negedge clk);
    n_checks++;
    if ({exception, vector, iack_n} !== {1'b1, 5'd8, 3'b110}) begin
      n_errors++;
      $display("FAIL int_then_ext: got %b want %b", {exception, vector, iack_n}, {1'b1, 5'd8, 3'b110});
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (nest_depth !== 3'd2) begin
      n_errors++;
      $display("FAIL int_depth: got %0d want 2", nest_depth);
    end
  endtask

  task automatic test_mask();
    bit seen;
    do_reset();
    ie = 1'b1;
    mask_we = 1'b1;
    mask_wdata = 3'b001;
    tick();
    mask_we = 1'b0;
    oint_n = 3'b110;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (exception) seen = 1'b1; tick(); end
    @(negedge clk);
    n_checks++;
    if ({seen, mask, pending} !== {1'b0, 3'b001, 3'b000}) begin
      n_errors++;
      $display("FAIL mask_blocks: got seen/mask/pending %b want %b", {seen, mask, pending}, {1'b0, 3'b001, 3'b000});
    end
    tick();
    mask_we = 1'b1;
    mask_wdata = 3'b000;
    @(negedge clk);
    n_checks++;
    if (exception !== 1'b0) begin
      n_errors++;
      $display("FAIL mask_write_cycle: got exception=%b want 0", exception);
    end
    tick();
    mask_we = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({exception, vector, iack_n, pending} !== {1'b1, 5'd8, 3'b110, 3'b001}) begin
      n_errors++;
      $display("FAIL unmask_take: got %b want %b", {exception, vector, iack_n, pending}, {1'b1, 5'd8, 3'b110, 3'b001});
    end
  endtask

  task automatic test_overflow();
    bit bad;
    bit seen;
    do_reset();
    vector_mem = 5'd16;
    bad = 1'b0;
    for (int c = 0; c < MAX_NEST; c++) begin
      @(negedge clk);
      if (!(exception === 1'b1 && vector === 5'd16)) bad = 1'b1;
      tick();
    end
    @(negedge clk);
    n_checks++;
    if ({bad, exception, vector, nest_depth, nest_ovf} !== {1'b0, 1'b1, 5'd16, 3'd4, 1'b0}) begin
      n_errors++;
      $display("FAIL ovf_fill: got %b want %b", {bad, exception, vector, nest_depth, nest_ovf}, {1'b0, 1'b1, 5'd16, 3'd4, 1'b0});
    end
    tick();
    vector_mem = '0;
    ie = 1'b1;
    oint_n = 3'b110;
    @(negedge clk);
    n_checks++;
    if ({nest_depth, nest_ovf} !== {3'd4, 1'b1}) begin
      n_errors++;
      $display("FAIL ovf_flag: got depth/ovf %b want %b", {nest_depth, nest_ovf}, {3'd4, 1'b1});
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin tick(); @(negedge clk); if (exception) seen = 1'b1; end
    n_checks++;
    if ({seen, pending} !== {1'b0, 3'b001}) begin
      n_errors++;
      $display("FAIL ovf_full_blocks: got seen/pending %b want %b", {seen, pending}, {1'b0, 3'b001});
    end
    tick();
    rfe = 1'b1;
    @(negedge clk);
    tick();
    rfe = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({exception, vector, iack_n, nest_depth, nest_ovf} !== {1'b1, 5'd8, 3'b110, 3'd3, 1'b1}) begin
      n_errors++;
      $display("FAIL ovf_after_pop: got %b want %b", {exception, vector, iack_n, nest_depth, nest_ovf},
               {1'b1, 5'd8, 3'b110, 3'd3, 1'b1});
    end
  endtask

  task automatic test_ie_gate();
    bit seen;
    do_reset();
    oint_n = 3'b101;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin tick(); @(negedge clk); if (exception) seen = 1'b1; end
    n_checks++;
    if ({seen, pending} !== {1'b0, 3'b010}) begin
      n_errors++;
      $display("FAIL ie_blocks: got seen/pending %b want %b", {seen, pending}, {1'b0, 3'b010});
    end
    tick();
    ie = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({exception, vector, iack_n} !== {1'b1, 5'd9, 3'b101}) begin
      n_errors++;
      $display("FAIL ie_take: got %b want %b", {exception, vector, iack_n}, {1'b1, 5'd9, 3'b101});
    end
  endtask

  task automatic test_reset_midservice();
    do_reset();
    vector_mem = 5'd3;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if (nest_depth !== 3'd2) begin
      n_errors++;
      $display("FAIL mid_fill: got depth %0d want 2", nest_depth);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({exception, vector, iack_n, nest_depth, nest_ovf} !== {1'b0, 5'd0, 3'b111, 3'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL mid_async_reset: got %b want %b", {exception, vector, iack_n, nest_depth, nest_ovf},
               {1'b0, 5'd0, 3'b111, 3'd0, 1'b0});
    end
    vector_mem = '0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({exception, nest_depth} !== {1'b0, 3'd0}) begin
      n_errors++;
      $display("FAIL mid_after_release: got %b want %b", {exception, nest_depth}, {1'b0, 3'd0});
    end
  endtask

  task automatic test_random();
    int kind, win;
    logic               eexc;
    logic [VEC_W-1:0]   evec;
    logic [NUM_IRQ-1:0] eack;
    logic [OBS_W-1:0]   got, exp;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      vector_mem = ($urandom_range(0, 15) == 0) ? VEC_W'($urandom_range(1, 31)) : '0;
      rfe        = ($urandom_range(0, 9) == 0);
      mask_we    = ($urandom_range(0, 19) == 0);
      mask_wdata = NUM_IRQ'($urandom);
      ie         = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) oint_n = NUM_IRQ'($urandom);
      @(negedge clk);
      model_decide(kind, win);
      eexc = (kind == K_INT) || (kind == K_EXT);
      evec = (kind == K_INT) ? vector_mem : (kind == K_EXT) ? VEC_W'(VEC_BASE + win) : '0;
      eack = '1;
      if (kind == K_EXT) eack[win] = 1'b0;
      got = {exception, vector, iack_n, pending, mask, nest_depth, nest_ovf};
      exp = {eexc, evec, eack, ~m_s2 & ~m_mask, m_mask, DEPTH_W'(m_stk.size()), m_ovf};
      n_checks++;
      if (got !== exp) begin
        n_errors++;
        $display("FAIL random cycle %0d: got %b want %b", c, got, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_nesting();
    test_internal_priority();
    test_mask();
    test_overflow();
    test_ie_gate();
    test_reset_midservice();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
